// File: rtl/memory_op_executor_if.sv
// Bundle of FIFO-consumer, memory-master and status signals for memory_op_executor.
// master: the executor; slave: the FIFO/memory/host side.
interface memory_op_executor_if #(
    parameter int unsigned address_size_memory = 10,
    parameter int unsigned data_size           = 32
) ();
    logic                           enable;
    logic                           fifo_empty;
    logic                           read;
    logic [address_size_memory-1:0] dest_addr;
    logic [address_size_memory-1:0] src1_addr;
    logic [address_size_memory-1:0] src2_addr;
    logic [1:0]                     mem_op;
    logic [address_size_memory-1:0] mem_addr;
    logic                           mem_rd_en;
    logic [data_size-1:0]           mem_rdata;
    logic                           mem_wr_en;
    logic [data_size-1:0]           mem_wdata;
    logic                           busy;
    logic                           op_done;
    logic [15:0]                    op_count;

    modport master (
        input  enable, fifo_empty, dest_addr, src1_addr, src2_addr, mem_op, mem_rdata,
        output read, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, op_done, op_count
    );

    modport slave (
        output enable, fifo_empty, dest_addr, src1_addr, src2_addr, mem_op, mem_rdata,
        input  read, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, busy, op_done, op_count
    );
endinterface

// File: rtl/memory_op_executor.sv
// Pops one {dest, src1, src2, op} entry at a time and runs its read/read/write sequence
// on a single-port synchronous memory; sole master of that memory port.
module memory_op_executor #(
    parameter int unsigned address_size_memory = 10,
    parameter int unsigned data_size           = 32
) (
    input logic                 clk_i,
    input logic                 reset_ni,
    memory_op_executor_if.master bus
);
    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpCopy = 2'b01;
    localparam logic [1:0] OpNor  = 2'b10;
    localparam logic [1:0] OpAnd  = 2'b11;

    typedef enum logic [2:0] {StIdle, StPop, StCapt, StRd1, StRd2, StWr} state_e;

    state_e                         state_q;
    logic [address_size_memory-1:0] d_q, s1_q, s2_q;
    logic [1:0]                     op_q;
    logic [data_size-1:0]           a_q;
    logic [15:0]                    op_count_q;

    logic                           read, rd_en, wr_en, op_done;
    logic [address_size_memory-1:0] addr;
    logic [data_size-1:0]           wdata, result;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            d_q        <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            op_q       <= OpNop;
            a_q        <= '0;
            op_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (bus.enable && !bus.fifo_empty) state_q <= StPop;
                StPop:  state_q <= StCapt;
                StCapt: begin
                    d_q     <= bus.dest_addr;
                    s1_q    <= bus.src1_addr;
                    s2_q    <= bus.src2_addr;
                    op_q    <= bus.mem_op;
                    state_q <= (bus.mem_op == OpNop) ? StIdle : StRd1;
                end
                StRd1:  state_q <= op_q[1] ? StRd2 : StWr;
                // mem_rdata here is the src1 word requested in RD1
                StRd2: begin
                    a_q     <= bus.mem_rdata;
                    state_q <= StWr;
                end
                StWr:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (op_done) op_count_q <= op_count_q + 16'd1;
        end
    end

    // In WR, mem_rdata carries src1 (COPY) or src2 (NOR/AND)
    always_comb begin
        result = '0;
        unique case (op_q)
            OpCopy:  result = bus.mem_rdata;
            OpNor:   result = ~(a_q | bus.mem_rdata);
            OpAnd:   result = a_q & bus.mem_rdata;
            default: result = '0;
        endcase
    end

    always_comb begin
        read    = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        op_done = 1'b0;
        addr    = '0;
        wdata   = '0;
        unique case (state_q)
            StPop:  read = 1'b1;
            StCapt: op_done = (bus.mem_op == OpNop);
            StRd1: begin
                addr  = s1_q;
                rd_en = 1'b1;
            end
            StRd2: begin
                addr  = s2_q;
                rd_en = 1'b1;
            end
            StWr: begin
                addr    = d_q;
                wr_en   = 1'b1;
                wdata   = result;
                op_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.read      = read;
    assign bus.mem_addr  = addr;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_wdata = wdata;
    assign bus.op_done   = op_done;
    assign bus.busy      = (state_q != StIdle);
    assign bus.op_count  = op_count_q;
endmodule
